// File: rtl/elevator_ctrl.sv
// ---------------------------------------------------------------------------
// elevator_ctrl
//
// Car-motion and door-sequencing controller. Floor call buttons are latched
// into a pending mask. The car moves one floor at a time using a SCAN policy
// (keep going in the current direction while requests remain ahead). It holds
// the door open for a fixed dwell at every floor it serves.
//
// Ports:
//   clk        - single clock, everything updates on the rising edge
//   reset      - synchronous, active-high reset
//   call       - call buttons, bit i requests floor i (level-sampled)
//   floor      - current car floor (registered)
//   door_open  - high while the door is open (drives indicator stage)
//   moving     - high while the car travels between floors
//   dir_up     - current travel direction, 1 = up
//   pending    - latched outstanding requests (registered)
// ---------------------------------------------------------------------------
module elevator_ctrl #(
  parameter int FLOORS        = 4,
  parameter int FLOOR_W       = 2,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOORS-1:0]  call,
  output logic [FLOOR_W-1:0] floor,
  output logic               door_open,
  output logic               moving,
  output logic               dir_up,
  output logic [FLOORS-1:0]  pending
);

  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [FLOOR_W-1:0] floor_next;
  logic               dir_next;
  logic [FLOORS-1:0]  pending_next;
  logic [TW-1:0]      tcnt, tcnt_next;
  logic [DW-1:0]      dcnt, dcnt_next;
  logic               above, below;

  // Summarise the registered request mask relative to the car: is anything
  // outstanding strictly above or strictly below the current floor?
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (pending[i] && (i > int'(floor))) above = 1'b1;
      if (pending[i] && (i < int'(floor))) below = 1'b1;
    end
  end

  // Next-state logic. Moves are entered only when a request lies strictly in
  // the chosen direction, so the floor index can never run off either end.
  // The request bit cleared while serving a stop is the bit for the floor the
  // car will be at after this edge, so an arrival clears the new floor.
  always_comb begin
    state_next = state;
    floor_next = floor;
    dir_next   = dir_up;
    tcnt_next  = tcnt;
    dcnt_next  = dcnt;

    case (state)
      IDLE: begin
        if (pending[floor]) begin
          state_next = DOOR;
        end else if (dir_up ? above : below) begin
          state_next = MOVE;
        end else if (dir_up ? below : above) begin
          state_next = MOVE;
          dir_next   = ~dir_up;
        end
      end
      MOVE: begin
        if (tcnt == TW'(TRAVEL_CYCLES - 1)) begin
          tcnt_next  = '0;
          floor_next = dir_up ? (floor + FLOOR_W'(1)) : (floor - FLOOR_W'(1));
          if (pending[floor_next]) state_next = DOOR;
        end else begin
          tcnt_next = tcnt + TW'(1);
        end
      end
      DOOR: begin
        if (dcnt == DW'(DOOR_CYCLES - 1)) begin
          dcnt_next  = '0;
          state_next = IDLE;
        end else begin
          dcnt_next = dcnt + DW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    pending_next = pending | call;
    if ((state == DOOR) || (state_next == DOOR)) pending_next[floor_next] = 1'b0;
  end

  // State register. door_open and moving are registered from the next state,
  // so they change cleanly on the clock edge without decode glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      floor     <= '0;
      dir_up    <= 1'b1;
      pending   <= '0;
      tcnt      <= '0;
      dcnt      <= '0;
      door_open <= 1'b0;
      moving    <= 1'b0;
    end else begin
      state     <= state_next;
      floor     <= floor_next;
      dir_up    <= dir_next;
      pending   <= pending_next;
      tcnt      <= tcnt_next;
      dcnt      <= dcnt_next;
      door_open <= (state_next == DOOR);
      moving    <= (state_next == MOVE);
    end
  end

endmodule

// File: tb/tb_elevator_ctrl.sv
// ---------------------------------------------------------------------------
// tb_elevator_ctrl
//
// Self-checking bench for elevator_ctrl. A behavioural car model tracks floor,
// direction, requests and the remaining time of the current leg or dwell.
// The DUT is compared against it every cycle, and directed scenarios pin key
// cycles with hand-computed values.
// ---------------------------------------------------------------------------
module tb_elevator_ctrl;

  localparam int FLOORS        = 4;
  localparam int FLOOR_W       = 2;
  localparam int TRAVEL_CYCLES = 4;
  localparam int DOOR_CYCLES   = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic [FLOORS-1:0]  call;
  logic [FLOOR_W-1:0] floor;
  logic               door_open;
  logic               moving;
  logic               dir_up;
  logic [FLOORS-1:0]  pending;

  int tests_run    = 0;
  int tests_failed = 0;
  bit check_en     = 1'b0;

  elevator_ctrl #(
    .FLOORS(FLOORS),
    .FLOOR_W(FLOOR_W),
    .TRAVEL_CYCLES(TRAVEL_CYCLES),
    .DOOR_CYCLES(DOOR_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .call(call),
    .floor(floor),
    .door_open(door_open),
    .moving(moving),
    .dir_up(dir_up),
    .pending(pending)
  );

  always #5 clk = ~clk;

  // One comparison: count it, and report a failure with both values.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive the call buttons for n cycles; returns at the negedge n cycles on.
  task automatic applyStimulus(input logic [FLOORS-1:0] c, input int n);
    for (int k = 0; k < n; k++) begin
      call = c;
      @(negedge clk);
    end
  endtask

  // Behavioural car model. mode: 0 idle, 1 travelling, 2 door open.
  // left counts the cycles remaining in the current floor leg or dwell.
  bit m_pend[FLOORS];
  int m_floor = 0;
  bit m_up    = 1'b1;
  int m_mode  = 0;
  int m_left  = 0;

  always @(posedge clk) begin : model
    bit nxt[FLOORS];
    bit ahead, behind, was_door;
    if (reset) begin
      for (int i = 0; i < FLOORS; i++) m_pend[i] = 1'b0;
      m_floor = 0;
      m_up    = 1'b1;
      m_mode  = 0;
      m_left  = 0;
    end else begin
      ahead  = 1'b0;
      behind = 1'b0;
      for (int i = 0; i < FLOORS; i++) begin
        if (m_pend[i] && (m_up ? (i > m_floor) : (i < m_floor))) ahead = 1'b1;
        if (m_pend[i] && (m_up ? (i < m_floor) : (i > m_floor))) behind = 1'b1;
        nxt[i] = m_pend[i] | call[i];
      end
      was_door = (m_mode == 2);
      case (m_mode)
        0: begin
          if (m_pend[m_floor]) begin
            m_mode = 2; m_left = DOOR_CYCLES;
          end else if (ahead) begin
            m_mode = 1; m_left = TRAVEL_CYCLES;
          end else if (behind) begin
            m_up = !m_up; m_mode = 1; m_left = TRAVEL_CYCLES;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_floor = m_up ? m_floor + 1 : m_floor - 1;
            if (m_pend[m_floor]) begin
              m_mode = 2; m_left = DOOR_CYCLES;
            end else begin
              m_left = TRAVEL_CYCLES;
            end
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      endcase
      if (was_door || (m_mode == 2)) nxt[m_floor] = 1'b0;
      for (int i = 0; i < FLOORS; i++) m_pend[i] = nxt[i];
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin : compare
    logic [FLOORS-1:0] mp;
    if (check_en) begin
      for (int i = 0; i < FLOORS; i++) mp[i] = m_pend[i];
      checkOutput("model_floor",   floor,     m_floor);
      checkOutput("model_door",    door_open, (m_mode == 2) ? 1 : 0);
      checkOutput("model_moving",  moving,    (m_mode == 1) ? 1 : 0);
      checkOutput("model_dir_up",  dir_up,    m_up);
      checkOutput("model_pending", pending,   mp);
      checkOutput("floor_in_range", (floor <= FLOOR_W'(FLOORS - 1)) ? 1 : 0, 1);
    end
  end

  initial begin
    reset = 1'b1;
    call  = '0;
    @(negedge clk);
    check_en = 1'b1;
    applyStimulus(4'b0000, 1);
    checkOutput("rst_floor",   floor,     0);
    checkOutput("rst_door",    door_open, 0);
    checkOutput("rst_moving",  moving,    0);
    checkOutput("rst_dir_up",  dir_up,    1);
    checkOutput("rst_pending", pending,   0);
    reset = 1'b0;

    // Local call at floor 0, pulsed in cycle 0.
    applyStimulus(4'b0001, 1);                              // cycle 1
    checkOutput("local_pend_c1", pending,   4'b0001);
    checkOutput("local_door_c1", door_open, 0);
    applyStimulus(4'b0000, 1);                              // cycle 2
    checkOutput("local_door_c2", door_open, 1);
    checkOutput("local_pend_c2", pending,   0);
    applyStimulus(4'b0000, 2);                              // cycle 4
    checkOutput("local_door_c4", door_open, 1);
    applyStimulus(4'b0000, 1);                              // cycle 5
    checkOutput("local_door_c5", door_open, 0);

    // Upward trip 0 -> 2.
    applyStimulus(4'b0100, 1);                              // cycle 1
    checkOutput("up_moving_c1", moving, 0);
    applyStimulus(4'b0000, 1);                              // cycle 2
    checkOutput("up_moving_c2", moving, 1);
    checkOutput("up_floor_c2",  floor,  0);
    applyStimulus(4'b0000, 4);                              // cycle 6
    checkOutput("up_floor_c6",  floor,  1);
    checkOutput("up_door_c6",   door_open, 0);
    applyStimulus(4'b0000, 4);                              // cycle 10
    checkOutput("up_floor_c10", floor,     2);
    checkOutput("up_door_c10",  door_open, 1);
    checkOutput("up_moving_c10", moving,   0);
    applyStimulus(4'b0000, 2);                              // cycle 12
    checkOutput("up_door_c12", door_open, 1);
    applyStimulus(4'b0000, 1);                              // cycle 13
    checkOutput("up_door_c13",   door_open, 0);
    checkOutput("up_moving_c13", moving,    0);

    // Direction reversal: at floor 2 going up, requests for 0 and 3.
    applyStimulus(4'b1001, 1);                              // cycle 1
    checkOutput("rev_pend_c1", pending, 4'b1001);
    applyStimulus(4'b0000, 5);                              // cycle 6
    checkOutput("rev_floor_c6", floor,     3);
    checkOutput("rev_door_c6",  door_open, 1);
    checkOutput("rev_pend_c6",  pending,   4'b0001);
    applyStimulus(4'b0000, 3);                              // cycle 9
    checkOutput("rev_door_c9", door_open, 0);
    checkOutput("rev_dir_c9",  dir_up,    1);
    applyStimulus(4'b0000, 1);                              // cycle 10
    checkOutput("rev_dir_c10",    dir_up, 0);
    checkOutput("rev_moving_c10", moving, 1);
    applyStimulus(4'b0000, 12);                             // cycle 22
    checkOutput("rev_floor_c22", floor,     0);
    checkOutput("rev_door_c22",  door_open, 1);
    checkOutput("rev_pend_c22",  pending,   0);
    applyStimulus(4'b0000, 3);                              // cycle 25

    // Intermediate stop: call 3 in cycle 0, call 1 in cycle 3.
    applyStimulus(4'b1000, 1);
    applyStimulus(4'b0000, 2);                              // cycle 3
    applyStimulus(4'b0010, 1);                              // cycle 4
    checkOutput("mid_pend_c4", pending, 4'b1010);
    applyStimulus(4'b0000, 2);                              // cycle 6
    checkOutput("mid_floor_c6", floor,     1);
    checkOutput("mid_door_c6",  door_open, 1);
    checkOutput("mid_dir_c6",   dir_up,    1);
    applyStimulus(4'b0000, 2);                              // cycle 8
    checkOutput("mid_door_c8", door_open, 1);
    applyStimulus(4'b0000, 1);                              // cycle 9
    checkOutput("mid_door_c9",   door_open, 0);
    checkOutput("mid_moving_c9", moving,    0);
    applyStimulus(4'b0000, 1);                              // cycle 10
    checkOutput("mid_moving_c10", moving, 1);
    applyStimulus(4'b0000, 4);                              // cycle 14
    checkOutput("mid_floor_c14", floor,     2);
    checkOutput("mid_door_c14",  door_open, 0);
    applyStimulus(4'b0000, 4);                              // cycle 18
    checkOutput("mid_floor_c18", floor,     3);
    checkOutput("mid_door_c18",  door_open, 1);
    applyStimulus(4'b0000, 3);                              // cycle 21
    checkOutput("mid_door_c21", door_open, 0);

    // Absorbed call: hold call[3] at floor 3 through the whole dwell.
    applyStimulus(4'b1000, 2);                              // cycle 2
    checkOutput("abs_door_c2", door_open, 1);
    checkOutput("abs_pend_c2", pending,   0);
    applyStimulus(4'b1000, 1);                              // cycle 3
    checkOutput("abs_door_c3", door_open, 1);
    applyStimulus(4'b1000, 2);                              // cycle 5
    checkOutput("abs_door_c5", door_open, 0);
    checkOutput("abs_pend_c5", pending,   0);
    applyStimulus(4'b0000, 2);                              // cycle 7
    checkOutput("abs_door_c7", door_open, 0);

    // Reset in the middle of a 1 -> 2 move.
    reset = 1'b1;
    applyStimulus(4'b0000, 2);
    reset = 1'b0;
    applyStimulus(4'b0100, 1);                              // cycle 1
    applyStimulus(4'b0000, 7);                              // cycle 8
    checkOutput("mrst_floor_c8",  floor,  1);
    checkOutput("mrst_moving_c8", moving, 1);
    reset = 1'b1;
    applyStimulus(4'b0000, 1);                              // cycle 9
    checkOutput("mrst_floor",   floor,     0);
    checkOutput("mrst_moving",  moving,    0);
    checkOutput("mrst_door",    door_open, 0);
    checkOutput("mrst_pending", pending,   0);
    checkOutput("mrst_dir_up",  dir_up,    1);
    reset = 1'b0;
    applyStimulus(4'b0000, 3);
    checkOutput("mrst_idle_floor",  floor,  0);
    checkOutput("mrst_idle_moving", moving, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl.md
# elevator_ctrl

Car-motion and door-sequencing controller for the elevator subsystem. It latches floor call buttons, moves the car floor-to-floor using a SCAN (continue-in-direction) policy, and holds the door open for a fixed dwell at each served floor. Its `door_open` output drives the input of the downstream red/green door-indicator stage directly: 1 = door open/boarding, 0 = closed/moving.

## Interface

Parameters:
- FLOORS, 4: number of floors, ≥2.
- FLOOR_W, 2: width of floor index, ≥ clog2(FLOORS).
- TRAVEL_CYCLES, 4: clock cycles to travel one floor, ≥1.
- DOOR_CYCLES, 3: cycles door_open stays high per stop, ≥1.

Ports:
- clk  input  1  single clock; everything updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- call  input  FLOORS  call buttons; bit i = request for floor i, level-sampled every cycle.
- floor  output  FLOOR_W  current car floor (registered).
- door_open  output  1  high while in DOOR state; feeds indicator stage input.
- moving  output  1  high while in MOVE state.
- dir_up  output  1  current travel direction, 1 = up.
- pending  output  FLOORS  latched outstanding requests (registered).

## Operation

- Reset (reset high at an edge): state=IDLE, floor=0, door_open=0, moving=0, dir_up=1, pending=0, travel/door counters=0. Reset overrides everything, including mid-move or mid-door; the car returns to floor 0 instantly.
- Request latching: each edge, pending <= pending | call, except the bit for `floor` is forced 0 when the next state is DOOR or the current state is DOOR. Calls for the current floor while the door is open are absorbed, with no extension of the dwell.
- "Above" = any pending bit with index > floor; "below" = any pending bit with index < floor. Both are computed from registered pending only.
- IDLE:
  - If pending[floor] is set, go to DOOR.
  - Else if a request exists in the dir_up direction, go to MOVE, keeping dir_up.
  - Else if a request exists in the opposite direction, flip dir_up and go to MOVE.
  - Else stay in IDLE.
- MOVE: the travel counter counts 0..TRAVEL_CYCLES-1. On the edge ending the last count:
  - floor <= floor ± 1 and the counter clears.
  - If pending[new floor] is set, go to DOOR on the same edge.
  - Otherwise remain in MOVE.
  - A request always exists ahead because pending clears only at DOOR.
  - floor never goes below 0 or above FLOORS-1. A move is only entered when a request exists strictly in that direction.
- DOOR: door_open=1 for exactly DOOR_CYCLES cycles, then IDLE. dir_up is unchanged. The next direction is chosen in IDLE.
- Simultaneous requests above and below while idle: current dir_up wins.

## Timing

- Call-to-pending latency: 1 cycle. A call asserted in cycle k shows in pending in cycle k+1.
- IDLE decision: made on the edge ending the cycle in which pending is visible. Call at the current floor in cycle k → door_open high cycles k+2..k+1+DOOR_CYCLES.
- Travel: each floor takes TRAVEL_CYCLES cycles from MOVE entry or from the previous floor change.
- Arrival edge: floor update and DOOR entry happen on the same edge, so door_open rises in the same cycle the new floor value appears.
- After DOOR, at least one IDLE cycle occurs before any new MOVE or DOOR.
- All outputs are registered and glitch-free.

## Test plan

- Reset values: hold reset 2 cycles → floor=0, door_open=0, moving=0, dir_up=1, pending=0. Assert reset in the middle of a MOVE from 1→2 → next cycle floor=0, state IDLE, pending=0.
- Local call (defaults): at floor 0, pulse call=4'b0001 in cycle 0.
  - pending[0]=1 in cycle 1.
  - door_open=1 in cycles 2,3,4 and 0 in cycle 5.
  - pending=0 from cycle 2.
- Upward trip: at floor 0 idle, pulse call[2] in cycle 0.
  - moving=1 from cycle 2.
  - floor=1 at cycle 6, floor=2 at cycle 10.
  - door_open=1 in cycles 10–12, IDLE at cycle 13.
- Intermediate stop: from floor 0, call[3] in cycle 0, then call[1] in cycle 3.
  - The car stops at floor 1 with door_open in cycles 6–8.
  - It resumes MOVE, reaches floor 2 four cycles after MOVE re-entry, then reaches floor 3 and opens.
- Direction reversal: car at floor 2 with dir_up=1, pending = {floor 0, floor 3} both set while idle.
  - The car serves floor 3 first.
  - Then dir_up flips to 0 in IDLE, and the car serves floor 0.
  - floor never exceeds 3 or goes below 0.
- Absorbed call during dwell: hold call[floor] high throughout DOOR → dwell is still exactly DOOR_CYCLES and pending[floor]=0 on exit.
